// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the RV32 hazard/flow controller.
// State encodings are kept as plain one-bit constants so older netlists can match them.
package hazard_ctrl_pkg;

    localparam int RA_W_DEF    = 5;
    localparam int CNT_W_DEF   = 32;
    localparam int TIMEOUT_DEF = 1024;

    localparam logic [0:0] ST_RUN      = 1'b0;
    localparam logic [0:0] ST_MEM_WAIT = 1'b1;

    typedef struct packed {
        logic pc_write;
        logic ifid_hazard;
        logic ifid_flush;
        logic idex_bubble;
        logic pipe_freeze;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '0;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Up-counter with enable and synchronous clear that sticks at MAX instead of wrapping.
// Used for the stall/flush performance counters and the memory-wait watchdog.
module hazard_ctrl_sat_counter #(
    parameter int           W   = 32,
    parameter logic [W-1:0] MAX = '1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
        return (v == MAX) ? v : v + 1'b1;
    endfunction

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= sat_inc(cnt_q);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/flow controller for the 5-stage RV32 core: load-use stalls, branch flushes,
// back-end freeze during data-memory waits, plus stall/flush counters and a wait watchdog.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int RA_W    = RA_W_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [RA_W-1:0]  id_rs1_i,
    input  logic [RA_W-1:0]  id_rs2_i,
    input  logic             id_use_rs1_i,
    input  logic             id_use_rs2_i,
    input  logic [RA_W-1:0]  ex_rd_i,
    input  logic             ex_memread_i,
    input  logic             id_br_taken_i,
    input  logic             mem_req_i,
    input  logic             mem_ack_i,
    output logic             pc_write_o,
    output logic             ifid_hazard_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             pipe_freeze_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic             mem_timeout_o
);

    localparam int                WAIT_W   = $clog2(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT - 1);

    logic [0:0]        state_q;
    logic [0:0]        state_d;
    logic [WAIT_W-1:0] wait_cnt;
    logic              load_use;
    logic              mem_stall;
    logic              wait_clr;
    logic              wait_en;
    logic              to_hit;
    logic              timeout_q;
    ctrl_t             ctrl;

    // x0 is hardwired zero, so a load targeting it can never feed a dependent.
    always_comb begin
        load_use = ex_memread_i && (ex_rd_i != '0) &&
                   ((id_use_rs1_i && (id_rs1_i == ex_rd_i)) ||
                    (id_use_rs2_i && (id_rs2_i == ex_rd_i)));
    end

    assign mem_stall = (state_q == ST_RUN) ? (mem_req_i && !mem_ack_i) : !mem_ack_i;

    // Freeze beats load-use beats branch; a stalled branch is re-seen next cycle.
    always_comb begin
        ctrl = CTRL_IDLE;
        if (start_i) begin
            if (mem_stall) begin
                ctrl.ifid_hazard = 1'b1;
                ctrl.pipe_freeze = 1'b1;
            end else if (load_use) begin
                ctrl.ifid_hazard = 1'b1;
                ctrl.idex_bubble = 1'b1;
            end else if (id_br_taken_i) begin
                ctrl.pc_write    = 1'b1;
                ctrl.ifid_flush  = 1'b1;
            end else begin
                ctrl.pc_write    = 1'b1;
            end
        end
    end

    assign pc_write_o    = ctrl.pc_write;
    assign ifid_hazard_o = ctrl.ifid_hazard;
    assign ifid_flush_o  = ctrl.ifid_flush;
    assign idex_bubble_o = ctrl.idex_bubble;
    assign pipe_freeze_o = ctrl.pipe_freeze;

    always_comb begin
        state_d = state_q;
        if (!start_i) begin
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_RUN:      if (mem_req_i && !mem_ack_i) state_d = ST_MEM_WAIT;
                ST_MEM_WAIT: if (mem_ack_i)               state_d = ST_RUN;
                default:                                  state_d = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Holding the wait counter clear throughout RUN guarantees it starts at zero on each wait.
    assign wait_clr = !start_i || (state_q == ST_RUN) || mem_ack_i;
    assign wait_en  = start_i && (state_q == ST_MEM_WAIT) && !mem_ack_i;
    assign to_hit   = start_i && (state_q == ST_MEM_WAIT) && (wait_cnt == WAIT_MAX);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            timeout_q <= 1'b0;
        end else if (to_hit) begin
            timeout_q <= 1'b1;
        end
    end

    assign mem_timeout_o = timeout_q;

    hazard_ctrl_sat_counter #(
        .W   (WAIT_W),
        .MAX (WAIT_MAX)
    ) u_wait_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (wait_clr),
        .en_i  (wait_en),
        .cnt_o (wait_cnt)
    );

    hazard_ctrl_sat_counter #(
        .W   (CNT_W),
        .MAX ('1)
    ) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (1'b0),
        .en_i  (start_i && !ctrl.pc_write),
        .cnt_o (stall_cnt_o)
    );

    hazard_ctrl_sat_counter #(
        .W   (CNT_W),
        .MAX ('1)
    ) u_flush_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (1'b0),
        .en_i  (ctrl.ifid_flush),
        .cnt_o (flush_cnt_o)
    );

endmodule
